// File: rtl/tank_turn_controller.sv
// tank_turn_controller
//
// Turn sequencer for a two-tank artillery game shown on an 8-digit display.
// It owns turn order, the per-turn move budget, fire charging, shell flight,
// hit resolution and both life counters.
//
// Digit map used throughout:
//   tank1_location[k] -> digit k+4 (k=1..3), so tank1 sits on digits 5..7
//   tank2_location[k] -> digit k   (k=0..2), so tank2 sits on digits 0..2
// Tank1 fires toward digit 0 and tank2 fires toward digit 7.
//
// Optional feature (macro TANK_TURN_TIMEOUT_EN):
//   When defined, a turn left idle in AIM for TIMEOUT_CYC cycles is forfeited.
//   When undefined, AIM waits forever and the idle counter does not exist.
//
// Ports
//   clk             in   system clock
//   rst             in   asynchronous reset, active high
//   fire            in   fire button level (synchronous, debounced)
//   button[1:0]     in   [1] moves toward digit 7, [0] toward digit 0
//   tank1_location  in   one-hot, bits [3:1] valid
//   tank2_location  in   one-hot, bits [2:0] valid
//   move_req[1:0]   out  one-cycle move strobe for the active tank
//   turn            out  0 = tank1 active, 1 = tank2 active
//   power[2:0]      out  current charge 0..7
//   shell_pos[7:0]  out  one-hot shell digit, 0 when no shell
//   hit1, hit2      out  one-cycle hit pulses
//   tank1_life      out  tank1 lives
//   tank2_life      out  tank2 lives
//   game_over       out  high in OVER
//   winner          out  valid with game_over: 0 = tank1, 1 = tank2
//   state_dbg[2:0]  out  current FSM state (AIM=0 CHARGE=1 FLIGHT=2
//                        RESOLVE=3 OVER=4)
//
// move_req is a plain strobe with no handshake: the location register is
// expected to act on every cycle it is non-zero.

module tank_turn_controller #(
  parameter int STEP_DIV    = 4,
  parameter int MOVES_MAX   = 2,
  parameter int LIFE_INIT   = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
  input  logic [1:0] button,
  input  logic [3:0] tank1_location,
  input  logic [3:0] tank2_location,
  output logic [1:0] move_req,
  output logic       turn,
  output logic [2:0] power,
  output logic [7:0] shell_pos,
  output logic       hit1,
  output logic       hit2,
  output logic [1:0] tank1_life,
  output logic [1:0] tank2_life,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_AIM     = 3'd0,
    S_CHARGE  = 3'd1,
    S_FLIGHT  = 3'd2,
    S_RESOLVE = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam int            SW         = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [1:0]    MOVES_INIT = 2'(MOVES_MAX);
  localparam logic [1:0]    LIFE_RST   = 2'(LIFE_INIT);

  // Elaboration-time guard against unusable parameter values.
  if (STEP_DIV < 1 || MOVES_MAX < 1 || MOVES_MAX > 3 ||
      LIFE_INIT < 1 || LIFE_INIT > 3 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("tank_turn_controller: parameter out of range");
  end

  // Position of the highest set bit of a one-hot location vector.
  function automatic logic [2:0] onehot_idx(input logic [3:0] v);
    onehot_idx = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) onehot_idx = 3'(i);
    end
  endfunction

  state_t        state, state_n;
  logic          fire_q;
  logic [1:0]    button_q;
  logic [SW-1:0] step_cnt, step_n;
  logic [1:0]    moves_left, moves_n;
  logic [2:0]    shell_dig, shell_dig_n;
  logic [3:0]    target, target_n;
  logic [1:0]    move_req_n;
  logic          turn_n;
  logic [2:0]    power_n;
  logic [7:0]    shell_pos_n;
  logic          hit1_n, hit2_n;
  logic [1:0]    life1_n, life2_n;
  logic          game_over_n, winner_n;

  // Decoded digits, edge detects and flight helpers.
  logic [2:0]    t1_dig, t2_dig, origin, opp_dig, next_dig;
  logic          fire_rise, at_edge, on_target, hit_now;
  logic [1:0]    button_rise;

`ifdef TANK_TURN_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] aim_cnt, aim_cnt_n;
`endif

  assign t1_dig    = 3'd4 + onehot_idx(tank1_location);
  assign t2_dig    = onehot_idx(tank2_location);
  assign origin    = turn ? t2_dig : t1_dig;
  assign opp_dig   = turn ? t1_dig : t2_dig;
  assign next_dig  = turn ? shell_dig + 3'd1 : shell_dig - 3'd1;
  // One more step would leave the display.
  assign at_edge   = turn ? (shell_dig == 3'd7) : (shell_dig == 3'd0);
  assign on_target = ({1'b0, shell_dig} == target);
  // target is 4-bit signed; bit 3 set means it lies outside 0..7.
  assign hit_now   = !target[3] && (target[2:0] == opp_dig);

  assign fire_rise   = fire & ~fire_q;
  assign button_rise = button & ~button_q;
  assign state_dbg   = state;

  always_comb begin
    state_n     = state;
    turn_n      = turn;
    power_n     = power;
    shell_pos_n = shell_pos;
    shell_dig_n = shell_dig;
    target_n    = target;
    step_n      = step_cnt;
    moves_n     = moves_left;
    move_req_n  = 2'b00;
    hit1_n      = 1'b0;
    hit2_n      = 1'b0;
    life1_n     = tank1_life;
    life2_n     = tank2_life;
    game_over_n = game_over;
    winner_n    = winner;
`ifdef TANK_TURN_TIMEOUT_EN
    aim_cnt_n   = '0;
`endif

    unique case (state)
      S_AIM: begin
`ifdef TANK_TURN_TIMEOUT_EN
        aim_cnt_n = aim_cnt + TW'(1);
`endif
        if (fire_rise) begin
          // A button edge in the same cycle is dropped.
          state_n = S_CHARGE;
          power_n = 3'd1;
          step_n  = '0;
`ifdef TANK_TURN_TIMEOUT_EN
          aim_cnt_n = '0;
        end else if (aim_cnt == TO_LAST) begin
          turn_n    = ~turn;
          moves_n   = MOVES_INIT;
          aim_cnt_n = '0;
`endif
        end else if (button_rise != 2'b00 && moves_left != 2'd0) begin
          // Clamping at the screen edge is done by the location register,
          // so a clamped move still costs budget.
          move_req_n = button_rise[1] ? 2'b10 : 2'b01;
          moves_n    = moves_left - 2'd1;
        end
      end

      S_CHARGE: begin
        if (!fire) begin
          state_n     = S_FLIGHT;
          shell_dig_n = origin;
          shell_pos_n = 8'd1 << origin;
          step_n      = '0;
          target_n    = turn ? ({1'b0, origin} + {1'b0, power})
                             : ({1'b0, origin} - {1'b0, power});
        end else if (step_cnt == STEP_LAST) begin
          step_n = '0;
          if (power != 3'd7) power_n = power + 3'd1;
        end else begin
          step_n = step_cnt + SW'(1);
        end
      end

      S_FLIGHT: begin
        // The shell dwells STEP_DIV cycles on every digit, including the
        // last one; the hit decision is taken at the end of that dwell so
        // the hit pulse lines up with the RESOLVE cycle.
        if (step_cnt == STEP_LAST) begin
          step_n = '0;
          if (on_target || at_edge) begin
            state_n = S_RESOLVE;
            if (hit_now) begin
              if (turn) begin
                hit1_n  = 1'b1;
                life1_n = (tank1_life != 2'd0) ? tank1_life - 2'd1 : 2'd0;
              end else begin
                hit2_n  = 1'b1;
                life2_n = (tank2_life != 2'd0) ? tank2_life - 2'd1 : 2'd0;
              end
            end
          end else begin
            shell_dig_n = next_dig;
            shell_pos_n = 8'd1 << next_dig;
          end
        end else begin
          step_n = step_cnt + SW'(1);
        end
      end

      S_RESOLVE: begin
        power_n     = 3'd0;
        shell_pos_n = 8'd0;
        // Lives were already updated on entry to RESOLVE.
        if ((turn ? tank1_life : tank2_life) == 2'd0) begin
          state_n     = S_OVER;
          game_over_n = 1'b1;
          winner_n    = turn;
        end else begin
          state_n = S_AIM;
          turn_n  = ~turn;
          moves_n = MOVES_INIT;
        end
      end

      S_OVER: begin
        // Terminal until reset.
      end

      default: state_n = S_AIM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_AIM;
      fire_q     <= 1'b0;
      button_q   <= 2'b00;
      step_cnt   <= '0;
      moves_left <= MOVES_INIT;
      shell_dig  <= 3'd0;
      target     <= 4'd0;
      move_req   <= 2'b00;
      turn       <= 1'b0;
      power      <= 3'd0;
      shell_pos  <= 8'd0;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      tank1_life <= LIFE_RST;
      tank2_life <= LIFE_RST;
      game_over  <= 1'b0;
      winner     <= 1'b0;
`ifdef TANK_TURN_TIMEOUT_EN
      aim_cnt    <= '0;
`endif
    end else begin
      state      <= state_n;
      fire_q     <= fire;
      button_q   <= button;
      step_cnt   <= step_n;
      moves_left <= moves_n;
      shell_dig  <= shell_dig_n;
      target     <= target_n;
      move_req   <= move_req_n;
      turn       <= turn_n;
      power      <= power_n;
      shell_pos  <= shell_pos_n;
      hit1       <= hit1_n;
      hit2       <= hit2_n;
      tank1_life <= life1_n;
      tank2_life <= life2_n;
      game_over  <= game_over_n;
      winner     <= winner_n;
`ifdef TANK_TURN_TIMEOUT_EN
      aim_cnt    <= aim_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_tank_turn_controller.sv
// Testbench for tank_turn_controller with STEP_DIV=4, MOVES_MAX=2, LIFE_INIT=3.
// Tank1 sits on digit 6, tank2 on digit 1 for the whole run.

module tb_tank_turn_controller;

  localparam logic [2:0] ST_AIM     = 3'd0;
  localparam logic [2:0] ST_CHARGE  = 3'd1;
  localparam logic [2:0] ST_FLIGHT  = 3'd2;
  localparam logic [2:0] ST_RESOLVE = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       fire;
  logic [1:0] button;
  logic [3:0] tank1_location, tank2_location;
  logic [1:0] move_req;
  logic       turn;
  logic [2:0] power;
  logic [7:0] shell_pos;
  logic       hit1, hit2;
  logic [1:0] tank1_life, tank2_life;
  logic       game_over, winner;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  tank_turn_controller #(
    .STEP_DIV(4), .MOVES_MAX(2), .LIFE_INIT(3), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .fire(fire), .button(button),
    .tank1_location(tank1_location), .tank2_location(tank2_location),
    .move_req(move_req), .turn(turn), .power(power), .shell_pos(shell_pos),
    .hit1(hit1), .hit2(hit2), .tank1_life(tank1_life), .tank2_life(tank2_life),
    .game_over(game_over), .winner(winner), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press fire, hold it for 'hold' further cycles, release, wait for RESOLVE.
  task automatic shoot(input int hold);
    int exp_pw;
    fire = 1'b1;
    tick();
    repeat (hold) tick();
    exp_pw = 1 + hold / 4;
    if (exp_pw > 7) exp_pw = 7;
    check("shoot_power", 32'(power), 32'(exp_pw));
    fire = 1'b0;
    for (int i = 0; i < 200 && state_dbg != ST_RESOLVE; i++) tick();
    check("shoot_resolve_reached", 32'(state_dbg), 32'(ST_RESOLVE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       fire;
    logic [1:0] button;
    logic [1:0] exp_move_req;
    logic [2:0] exp_power;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[11];

  task automatic apply_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      fire   = vecs[i].fire;
      button = vecs[i].button;
      tick();
      check($sformatf("vec%0d_move_req", i), 32'(move_req), 32'(vecs[i].exp_move_req));
      check($sformatf("vec%0d_power", i), 32'(power), 32'(vecs[i].exp_power));
      check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].exp_state));
    end
  endtask

  logic [7:0] one8;

  initial begin
    one8 = 8'd1;
    // Turn 0 (tank1): three button[0] edges, only two accepted, then fire.
    vecs[0] = '{1'b0, 2'b00, 2'b00, 3'd0, ST_AIM};
    vecs[1] = '{1'b0, 2'b01, 2'b01, 3'd0, ST_AIM};
    vecs[2] = '{1'b0, 2'b00, 2'b00, 3'd0, ST_AIM};
    vecs[3] = '{1'b0, 2'b01, 2'b01, 3'd0, ST_AIM};
    vecs[4] = '{1'b0, 2'b00, 2'b00, 3'd0, ST_AIM};
    vecs[5] = '{1'b0, 2'b01, 2'b00, 3'd0, ST_AIM};
    vecs[6] = '{1'b0, 2'b00, 2'b00, 3'd0, ST_AIM};
    vecs[7] = '{1'b1, 2'b01, 2'b00, 3'd1, ST_CHARGE};
    // Turn 1 (tank2): both buttons rise -> button[1] wins; fire+button -> no move.
    vecs[8]  = '{1'b0, 2'b11, 2'b10, 3'd0, ST_AIM};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 3'd0, ST_AIM};
    vecs[10] = '{1'b1, 2'b01, 2'b00, 3'd1, ST_CHARGE};

    // ---------- test 1: reset ----------
    rst = 1'b1;
    fire = 1'b0;
    button = 2'b00;
    tank1_location = 4'b0100;
    tank2_location = 4'b0010;
    tick();
    tick();
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_life1", 32'(tank1_life), 32'd3);
    check("rst_life2", 32'(tank2_life), 32'd3);
    check("rst_shell", 32'(shell_pos), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_AIM));
    rst = 1'b0;

    // ---------- test 2: move budget, fire edge ----------
    apply_vectors(0, 7);

    // ---------- test 3: charge to 5, fly 6 -> 1, hit tank2 ----------
    repeat (15) tick();
    check("t3_power_4", 32'(power), 32'd4);
    tick();
    check("t3_power_5", 32'(power), 32'd5);
    fire = 1'b0;
    button = 2'b00;
    tick();
    check("t3_flight_state", 32'(state_dbg), 32'(ST_FLIGHT));
    for (int d = 6; d >= 1; d--) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("t3_shell_d%0d_c%0d", d, j), 32'(shell_pos), 32'(one8 << d));
        check("t3_no_hit_in_flight", 32'(hit2), 32'd0);
        tick();
      end
    end
    check("t3_resolve_state", 32'(state_dbg), 32'(ST_RESOLVE));
    check("t3_hit2", 32'(hit2), 32'd1);
    check("t3_hit1", 32'(hit1), 32'd0);
    check("t3_life2", 32'(tank2_life), 32'd2);
    check("t3_life1", 32'(tank1_life), 32'd3);
    tick();
    check("t3_hit2_pulse_end", 32'(hit2), 32'd0);
    check("t3_turn", 32'(turn), 32'd1);
    check("t3_state_aim", 32'(state_dbg), 32'(ST_AIM));
    check("t3_power_clr", 32'(power), 32'd0);
    check("t3_shell_clr", 32'(shell_pos), 32'd0);

    // ---------- test 4: tank2 off-screen miss with saturated power ----------
    apply_vectors(8, 10);
    button = 2'b00;
    repeat (40) tick();
    check("t4_power_sat", 32'(power), 32'd7);
    fire = 1'b0;
    tick();
    for (int d = 1; d <= 7; d++) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("t4_shell_d%0d_c%0d", d, j), 32'(shell_pos), 32'(one8 << d));
        tick();
      end
    end
    check("t4_resolve_state", 32'(state_dbg), 32'(ST_RESOLVE));
    check("t4_shell_edge", 32'(shell_pos), 32'h80);
    check("t4_no_hit", 32'({hit1, hit2}), 32'd0);
    check("t4_life1", 32'(tank1_life), 32'd3);
    tick();
    check("t4_turn_back", 32'(turn), 32'd0);
    check("t4_shell_clr", 32'(shell_pos), 32'd0);

    // ---------- test 5: exchange of fire to game over ----------
    shoot(16);
    check("t5a_hit2", 32'(hit2), 32'd1);
    check("t5a_life2", 32'(tank2_life), 32'd1);
    tick();
    check("t5a_turn", 32'(turn), 32'd1);
    shoot(16);
    check("t5b_hit1", 32'(hit1), 32'd1);
    check("t5b_life1", 32'(tank1_life), 32'd2);
    tick();
    check("t5b_turn", 32'(turn), 32'd0);
    shoot(16);
    check("t5c_hit2", 32'(hit2), 32'd1);
    check("t5c_life2", 32'(tank2_life), 32'd0);
    tick();
    check("t5_state_over", 32'(state_dbg), 32'(ST_OVER));
    check("t5_game_over", 32'(game_over), 32'd1);
    check("t5_winner", 32'(winner), 32'd0);
    for (int i = 0; i < 6; i++) begin
      fire = i[0];
      button = i[0] ? 2'b11 : 2'b00;
      tick();
      check("t5_over_state", 32'(state_dbg), 32'(ST_OVER));
      check("t5_over_move_req", 32'(move_req), 32'd0);
      check("t5_over_power", 32'(power), 32'd0);
      check("t5_over_turn", 32'(turn), 32'd0);
    end
    fire = 1'b0;
    button = 2'b00;

    // ---------- test 6: reset in the middle of a flight ----------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_game_over_cleared", 32'(game_over), 32'd0);
    fire = 1'b1;
    tick();
    repeat (4) tick();
    fire = 1'b0;
    tick();
    tick();
    check("t6_in_flight", 32'(state_dbg), 32'(ST_FLIGHT));
    check("t6_in_flight_shell", 32'(shell_pos), 32'h40);
    rst = 1'b1;
    #1;
    check("t6_rst_state", 32'(state_dbg), 32'(ST_AIM));
    check("t6_rst_shell", 32'(shell_pos), 32'd0);
    check("t6_rst_power", 32'(power), 32'd0);
    check("t6_rst_turn", 32'(turn), 32'd0);
    check("t6_rst_hits", 32'({hit1, hit2}), 32'd0);
    check("t6_rst_lives", 32'({tank1_life, tank2_life}), 32'h0f);
    tick();
    rst = 1'b0;
    tick();
    check("t6_after_rst_turn", 32'(turn), 32'd0);
    check("t6_after_rst_state", 32'(state_dbg), 32'(ST_AIM));

`ifdef TANK_TURN_TIMEOUT_EN
    // ---------- idle timeout forfeits the turn ----------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();
    check("to_turn_before", 32'(turn), 32'd0);
    tick();
    check("to_turn_after", 32'(turn), 32'd1);
    check("to_no_hit", 32'({hit1, hit2}), 32'd0);
    check("to_no_shell", 32'(shell_pos), 32'd0);
`endif

    // ---------- final report ----------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
